// File: rtl/reaction_rounds.sv
// Multi-round reaction-time game engine: timed trials with false-start detection,
// per-round score, floor average over ROUNDS and a best-average high score.
module reaction_rounds #(
  parameter int TICK_DIV      = 50000,
  parameter int SCORE_W       = 14,
  parameter int ROUNDS        = 4,
  parameter int DELAY_MIN_MS  = 1000,
  parameter int DELAY_RANGE_W = 11,
  parameter int TIMEOUT_MS    = 9999
) (
  input  logic               clk,
  input  logic               iReset,
  input  logic               spacePressed,
  input  logic               onePressed,
  output logic [2:0]         screen,
  output logic [3:0]         roundIdx,
  output logic [SCORE_W-1:0] currentScore,
  output logic [SCORE_W-1:0] averageScore,
  output logic [SCORE_W-1:0] highScore,
  output logic               falseStart
);

  localparam int SUM_W = SCORE_W + 3;
  localparam int SHIFT = $clog2(ROUNDS);
  localparam int DLY_W = $clog2(DELAY_MIN_MS + 2**DELAY_RANGE_W);
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_GO      = 3'd2,
    S_RESULT  = 3'd3,
    S_FALSE   = 3'd4,
    S_SUMMARY = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic               spPrev_q, onePrev_q;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [PRE_W-1:0]   presc_q, presc_d;
  logic [DLY_W-1:0]   downCnt_q, downCnt_d;
  logic [SCORE_W-1:0] upCnt_q, upCnt_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [3:0]         round_q, round_d;
  logic [SCORE_W-1:0] cur_q, cur_d;
  logic [SCORE_W-1:0] avg_q, avg_d;
  logic [SCORE_W-1:0] high_q, high_d;

  logic               spEdge, oneEdge, tick, waitDone, timeoutHit;
  logic [SCORE_W-1:0] avgNew;

  // Space wins over one when both rise in the same cycle.
  assign spEdge     = spacePressed & ~spPrev_q;
  assign oneEdge    = onePressed & ~onePrev_q & ~spEdge;
  assign tick       = (presc_q == PRE_W'(TICK_DIV - 1));
  assign waitDone   = tick && (downCnt_q == DLY_W'(1));
  assign timeoutHit = tick && (upCnt_q == SCORE_W'(TIMEOUT_MS - 1));
  assign avgNew     = SCORE_W'(sum_q >> SHIFT);

  always_ff @(posedge clk or negedge iReset) begin
    if (!iReset) begin
      state_q   <= S_IDLE;
      spPrev_q  <= 1'b0;
      onePrev_q <= 1'b0;
      lfsr_q    <= 16'hACE1;
      presc_q   <= '0;
      downCnt_q <= '0;
      upCnt_q   <= '0;
      sum_q     <= '0;
      round_q   <= '0;
      cur_q     <= '0;
      avg_q     <= '0;
      high_q    <= '0;
    end else begin
      state_q   <= state_d;
      spPrev_q  <= spacePressed;
      onePrev_q <= onePressed;
      lfsr_q    <= lfsr_d;
      presc_q   <= presc_d;
      downCnt_q <= downCnt_d;
      upCnt_q   <= upCnt_d;
      sum_q     <= sum_d;
      round_q   <= round_d;
      cur_q     <= cur_d;
      avg_q     <= avg_d;
      high_q    <= high_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (oneEdge) state_d = S_WAIT;
      S_WAIT: begin
        if (spEdge)        state_d = S_FALSE;
        else if (waitDone) state_d = S_GO;
      end
      S_GO:      if (spEdge || timeoutHit) state_d = S_RESULT;
      S_RESULT:  if (oneEdge) state_d = (round_q == LAST_ROUND) ? S_SUMMARY : S_WAIT;
      S_FALSE:   if (oneEdge) state_d = S_WAIT;
      S_SUMMARY: if (oneEdge) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath: timers restart on entry to WAIT/GO; scores latch on the cycle a trial ends.
  always_comb begin
    logic [SCORE_W-1:0] score;
    score     = upCnt_q;
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    presc_d   = tick ? '0 : presc_q + PRE_W'(1);
    downCnt_d = downCnt_q;
    upCnt_d   = upCnt_q;
    sum_d     = sum_q;
    round_d   = round_q;
    cur_d     = cur_q;
    avg_d     = avg_q;
    high_d    = high_q;

    if (state_d == S_WAIT && state_q != S_WAIT) begin
      presc_d   = '0;
      downCnt_d = DLY_W'(DELAY_MIN_MS) + DLY_W'(lfsr_q[DELAY_RANGE_W-1:0]);
    end else if (state_q == S_WAIT && tick && downCnt_q != '0) begin
      downCnt_d = downCnt_q - DLY_W'(1);
    end

    if (state_d == S_GO && state_q != S_GO) begin
      presc_d = '0;
      upCnt_d = '0;
    end else if (state_q == S_GO && tick && upCnt_q < SCORE_W'(TIMEOUT_MS)) begin
      upCnt_d = upCnt_q + SCORE_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (oneEdge) begin
          sum_d   = '0;
          round_d = '0;
        end
      end
      S_GO: begin
        if (spEdge || timeoutHit) begin
          score = spEdge ? upCnt_q : SCORE_W'(TIMEOUT_MS);
          cur_d = score;
          sum_d = sum_q + SUM_W'(score);
        end
      end
      S_RESULT: begin
        if (oneEdge && round_q != LAST_ROUND) begin
          round_d = round_q + 4'd1;
        end else if (oneEdge) begin
          avg_d = avgNew;
          if (high_q == '0 || avgNew < high_q) high_d = avgNew;
        end
      end
      default: ;
    endcase
  end

  assign screen       = state_q;
  assign roundIdx     = round_q;
  assign currentScore = cur_q;
  assign averageScore = avg_q;
  assign highScore    = high_q;
  assign falseStart   = (state_q == S_FALSE);

endmodule

// File: tb/tb_reaction_rounds.sv
// Self-checking bench for reaction_rounds: timestamp-based game model compared every
// cycle, plus directed games with hand-computed scores, averages and high scores.
module tb_reaction_rounds;

  localparam int TICK_DIV      = 4;
  localparam int SCORE_W       = 14;
  localparam int ROUNDS        = 4;
  localparam int DELAY_MIN_MS  = 10;
  localparam int DELAY_RANGE_W = 4;
  localparam int TIMEOUT_MS    = 9999;

  logic               clk = 1'b0;
  logic               iReset = 1'b0;
  logic               spacePressed = 1'b0;
  logic               onePressed = 1'b0;
  logic [2:0]         screen;
  logic [3:0]         roundIdx;
  logic [SCORE_W-1:0] currentScore, averageScore, highScore;
  logic               falseStart;

  int total = 0;
  int bad   = 0;

  reaction_rounds #(
    .TICK_DIV(TICK_DIV), .SCORE_W(SCORE_W), .ROUNDS(ROUNDS),
    .DELAY_MIN_MS(DELAY_MIN_MS), .DELAY_RANGE_W(DELAY_RANGE_W), .TIMEOUT_MS(TIMEOUT_MS)
  ) dut (
    .clk(clk), .iReset(iReset), .spacePressed(spacePressed), .onePressed(onePressed),
    .screen(screen), .roundIdx(roundIdx), .currentScore(currentScore),
    .averageScore(averageScore), .highScore(highScore), .falseStart(falseStart)
  );

  always #5 clk = ~clk;

  // Game model: phases are driven by absolute edge timestamps, not by counters.
  longint t = 0;
  always @(posedge clk) t <= t + 1;

  int          mScreen, mRound, mCur, mAvg, mHigh, mSum;
  longint      mDeadline, mGoStart;
  logic        mSp, mOne;
  logic [15:0] mLfsr;

  function automatic longint waitLen(input logic [15:0] l);
    logic [DELAY_RANGE_W-1:0] s;
    s = l[DELAY_RANGE_W-1:0];
    return longint'(TICK_DIV) * longint'(DELAY_MIN_MS + int'(s));
  endfunction

  always @(posedge clk or negedge iReset) begin
    if (!iReset) begin
      mScreen <= 0; mRound <= 0; mCur <= 0; mAvg <= 0; mHigh <= 0; mSum <= 0;
      mDeadline <= 0; mGoStart <= 0; mSp <= 1'b0; mOne <= 1'b0; mLfsr <= 16'hACE1;
    end else begin
      logic   sE, oE;
      int     score, avg;
      longint elapsed;
      sE = spacePressed && !mSp;
      oE = onePressed && !mOne && !sE;
      mSp   <= spacePressed;
      mOne  <= onePressed;
      mLfsr <= {mLfsr[14:0], mLfsr[15] ^ mLfsr[13] ^ mLfsr[12] ^ mLfsr[10]};
      case (mScreen)
        0: if (oE) begin
          mSum <= 0; mRound <= 0; mScreen <= 1; mDeadline <= t + waitLen(mLfsr);
        end
        1: begin
          if (sE) mScreen <= 4;
          else if (t == mDeadline) begin mScreen <= 2; mGoStart <= t; end
        end
        2: begin
          elapsed = (t - mGoStart - 1) / TICK_DIV;
          if (sE || t == mGoStart + longint'(TICK_DIV) * TIMEOUT_MS) begin
            score = sE ? int'(elapsed) : TIMEOUT_MS;
            mCur <= score; mSum <= mSum + score; mScreen <= 3;
          end
        end
        3: if (oE) begin
          if (mRound == ROUNDS - 1) begin
            avg = mSum / ROUNDS;
            mAvg <= avg;
            if (mHigh == 0 || avg < mHigh) mHigh <= avg;
            mScreen <= 5;
          end else begin
            mRound <= mRound + 1; mScreen <= 1; mDeadline <= t + waitLen(mLfsr);
          end
        end
        4: if (oE) begin mScreen <= 1; mDeadline <= t + waitLen(mLfsr); end
        5: if (oE) mScreen <= 0;
        default: mScreen <= 0;
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    total = total + 1;
    if (int'(screen) !== mScreen || int'(roundIdx) !== mRound || int'(currentScore) !== mCur ||
        int'(averageScore) !== mAvg || int'(highScore) !== mHigh || falseStart !== (mScreen == 4)) begin
      bad = bad + 1;
      $display("[TB] FAIL model t=%0d got scr=%0d rnd=%0d cur=%0d avg=%0d hi=%0d fs=%0b want scr=%0d rnd=%0d cur=%0d avg=%0d hi=%0d fs=%0b",
               t, screen, roundIdx, currentScore, averageScore, highScore, falseStart,
               mScreen, mRound, mCur, mAvg, mHigh, (mScreen == 4));
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total = total + 1;
    if (actual !== expected) begin
      bad = bad + 1;
      $display("[TB] FAIL %s got=%0d want=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic sp, input logic one);
    spacePressed = sp;
    onePressed   = one;
    @(negedge clk);
  endtask

  task automatic pressOne();
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic waitScreen(input int val, input int budget);
    int n = 0;
    while (int'(screen) != val && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait screen", int'(screen), val);
  endtask

  // Press space so that exactly ms whole ticks have elapsed in GO.
  task automatic react(input int ms);
    waitScreen(2, 400);
    repeat (TICK_DIV * ms + 1) @(negedge clk);
    applyStimulus(1'b1, 1'b0);
    checkOutput("result screen", int'(screen), 3);
    checkOutput("round score", int'(currentScore), ms);
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic playGame(input int s0, input int s1, input int s2, input int s3,
                          input int expAvg, input int expHigh);
    int s[4];
    s = '{s0, s1, s2, s3};
    pressOne();
    for (int i = 0; i < 4; i++) begin
      checkOutput("round index", int'(roundIdx), i);
      react(s[i]);
      pressOne();
    end
    checkOutput("summary screen", int'(screen), 5);
    checkOutput("average", int'(averageScore), expAvg);
    checkOutput("high score", int'(highScore), expHigh);
    pressOne();
    checkOutput("back to idle", int'(screen), 0);
    checkOutput("average kept", int'(averageScore), expAvg);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset screen", int'(screen), 0);
    checkOutput("reset high", int'(highScore), 0);
    iReset = 1'b1;
    @(negedge clk);

    // Space and one rising together in IDLE, then held: no start.
    applyStimulus(1'b1, 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("held keys idle", int'(screen), 0);
    applyStimulus(1'b0, 1'b0);

    // Game A: simultaneous keys in RESULT, false start in round 1.
    pressOne();
    checkOutput("start wait", int'(screen), 1);
    react(100);
    applyStimulus(1'b1, 1'b1);
    checkOutput("space priority result", int'(screen), 3);
    applyStimulus(1'b0, 1'b0);
    pressOne();
    checkOutput("round1 wait", int'(screen), 1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("false screen", int'(screen), 4);
    checkOutput("false flag", int'(falseStart), 1);
    checkOutput("false round", int'(roundIdx), 1);
    applyStimulus(1'b0, 1'b0);
    pressOne();
    checkOutput("retry screen", int'(screen), 1);
    checkOutput("retry round", int'(roundIdx), 1);
    checkOutput("retry flag", int'(falseStart), 0);
    react(200);
    pressOne();
    react(300);
    pressOne();
    react(401);
    pressOne();
    checkOutput("A summary", int'(screen), 5);
    checkOutput("A average", int'(averageScore), 250);
    checkOutput("A high", int'(highScore), 250);
    pressOne();
    checkOutput("A idle", int'(screen), 0);

    playGame(300, 300, 300, 300, 300, 250);
    playGame(200, 200, 200, 200, 200, 200);
    playGame(199, 201, 200, 203, 200, 200);

    // Timeout round, then reset in the middle of the next GO.
    pressOne();
    waitScreen(2, 400);
    waitScreen(3, TICK_DIV * TIMEOUT_MS + 50);
    checkOutput("timeout score", int'(currentScore), TIMEOUT_MS);
    checkOutput("timeout round", int'(roundIdx), 0);
    pressOne();
    waitScreen(2, 400);
    repeat (10) @(negedge clk);
    iReset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst screen", int'(screen), 0);
    checkOutput("rst round", int'(roundIdx), 0);
    checkOutput("rst current", int'(currentScore), 0);
    checkOutput("rst average", int'(averageScore), 0);
    checkOutput("rst high", int'(highScore), 0);
    checkOutput("rst false", int'(falseStart), 0);
    iReset = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0);
    checkOutput("space idle", int'(screen), 0);
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reaction_rounds.md
Name: reaction_rounds

Overview:
- Multi-round reaction-time game engine: the parametrised successor to the single-shot reaction game.
- Runs ROUNDS timed trials and detects false starts (early presses).
- Reports each trial's score, the running round index and the average over all rounds. The best (lowest) average is kept as the high score.
- Sits between the keyboard decoder (spacePressed/onePressed levels) and the VGA/HEX display logic, which renders according to the screen code.
- Contains its own millisecond prescaler and LFSR, so no external PRNG is needed.

Parameters:
- TICK_DIV, 50000: clock cycles per 1 ms tick (50 MHz board clock).
- SCORE_W, 14: width of all score outputs, in ms.
- ROUNDS, 4: trials per game; legal values are 1, 2, 4, 8 (power of two, so the average is a shift).
- DELAY_MIN_MS, 1000: minimum random wait before GO.
- DELAY_RANGE_W, 11: LFSR bits added to the minimum; wait is DELAY_MIN_MS .. DELAY_MIN_MS + 2^W - 1 ms.
- TIMEOUT_MS, 9999: GO-phase limit; must be at most 2^SCORE_W - 1.

Ports:
- clk, input, 1: system clock.
- iReset, input, 1: asynchronous active-low reset.
- spacePressed, input, 1: space key level, synchronous to clk.
- onePressed, input, 1: '1' key level, synchronous to clk.
- screen, output, 3: 0 IDLE, 1 WAIT, 2 GO, 3 RESULT, 4 FALSE, 5 SUMMARY.
- roundIdx, output, 4: current round, 0-based.
- currentScore, output, SCORE_W: last trial time in ms.
- averageScore, output, SCORE_W: sum of round scores divided by ROUNDS; valid in SUMMARY.
- highScore, output, SCORE_W: best average since reset; 0 means no record.
- falseStart, output, 1: high while in FALSE.

Behaviour:
- Reset (iReset=0, asynchronous):
  - state IDLE, screen=0, roundIdx=0.
  - currentScore, averageScore, highScore and falseStart all 0.
  - prescaler 0; LFSR = 16'hACE1.
  - Reset mid-game abandons everything, including highScore.
- Key handling: rising edges only. Each key has a registered previous value; edge = level & ~prev. A held key never re-triggers.
- Simultaneous edges: space takes priority over one.
- LFSR:
  - 16-bit Fibonacci, taps 16, 14, 13, 11.
  - Advances every clock in every state except reset.
  - The delay sample is LFSR[DELAY_RANGE_W-1:0], taken at the cycle of entry into WAIT.
- Prescaler:
  - Counts 0..TICK_DIV-1; tick pulses on the cycle it wraps.
  - Cleared to 0 on every entry to WAIT or GO, so the first tick comes TICK_DIV cycles after entry.
- IDLE:
  - one edge: clear sum and roundIdx, go to WAIT.
  - space edge: ignored.
- WAIT:
  - Load down-counter = DELAY_MIN_MS + sample; decrement once per tick.
  - Counter reaching 0 on a tick: go to GO, clear the up-counter.
  - space edge before that: go to FALSE (falseStart=1). The round is not counted and roundIdx does not change.
  - A space edge in the same cycle as the counter reaching 0 counts as a false start.
- GO:
  - Up-counter increments per tick.
  - space edge: currentScore = counter, sum += counter, go to RESULT. Latency is 1 clock from the edge.
  - Counter reaching TIMEOUT_MS: currentScore = TIMEOUT_MS, added to sum, go to RESULT.
- RESULT:
  - one edge, roundIdx < ROUNDS-1: roundIdx++, go to WAIT.
  - one edge, roundIdx = ROUNDS-1: averageScore = sum >> log2(ROUNDS), go to SUMMARY.
- FALSE:
  - one edge: retry the same round (go to WAIT, new delay sample), falseStart=0.
- SUMMARY:
  - On entry, in the same cycle as averageScore is written: if highScore==0 or the new average < highScore, highScore takes the new average. A tie keeps the old value.
  - one edge: go to IDLE; averageScore and highScore are retained.
- Widths:
  - sum register is SCORE_W+3 bits, so it cannot overflow for 8 rounds.
  - The average is truncated (floor).
  - The up-counter saturates; it can never wrap.
- Outputs are registered; screen changes the cycle after the causing edge or tick.

Test Plan:
- Reset: hold iReset=0 mid-GO, then release. All outputs 0, screen=0, highScore=0. Pressing space in IDLE leaves screen=0.
- Normal game (TICK_DIV=4, ROUNDS=4): react after 100, 200, 300, 401 ms. currentScore follows each value; SUMMARY shows averageScore=250 (1001>>2); highScore=250.
- False start: space during WAIT of round 2 gives screen=4 and falseStart=1. A one edge then gives screen=1 with roundIdx still 1; the game completes with 4 counted scores.
- Timeout: no space in GO. After TIMEOUT_MS ticks, currentScore=9999 and screen=3.
- High score: a second game with average 300 leaves highScore=250; a third with average 200 sets highScore=200; a tie at 200 leaves it unchanged.
- Edge/priority: space and one held from IDLE cause no start. Space and one rising together in RESULT are treated as space (ignored), so the state stays RESULT.
